ds_serial_tx: RTL and testbench

DS_SERIAL_TX -- requirements
Module: ds_serial_tx

---
 rtl/ds_serial_tx.sv | 159 +++++++++++++++
 tb/tb_ds_serial_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ds_serial_tx.sv
// Differential UART-style serial transmitter with a registered FSM.
// Define DS_SERIAL_TX_PARITY_EN to add an even-parity bit after the data.
module O_BUF_DS (
  input  logic I,
  output logic O_P,
  output logic O_N
);
  assign O_P = I;
  assign O_N = ~I;
endmodule

module ds_serial_tx #(
  parameter int WIDTH    = 8,
  parameter int BAUD_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             busy,
  output logic             tx_p,
  output logic             tx_n
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef DS_SERIAL_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] sh_nxt;
  logic             tx_bit_q, tx_bit_d;
  logic             rdy_q, rdy_d;
  logic             baud_end;
`ifdef DS_SERIAL_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign baud_end = (baud_q == 16'(BAUD_DIV - 1));
  assign sh_nxt   = sh_q >> 1;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    tx_bit_d = tx_bit_q;
    rdy_d    = rdy_q;
`ifdef DS_SERIAL_TX_PARITY_EN
    par_d    = par_q;
`endif
    if (state_q != IDLE)
      baud_d = baud_end ? 16'd0 : baud_q + 16'd1;
    unique case (state_q)
      IDLE: begin
        rdy_d    = 1'b1;
        tx_bit_d = 1'b1;
        // rdy_q gates acceptance so the cycle after reset ignores din_valid
        if (din_valid && rdy_q) begin
          state_d  = START;
          sh_d     = din;
          tx_bit_d = 1'b0;
          rdy_d    = 1'b0;
          baud_d   = 16'd0;
          bit_d    = '0;
`ifdef DS_SERIAL_TX_PARITY_EN
          par_d    = ^din;
`endif
        end
      end
      START: begin
        if (baud_end) begin
          state_d  = DATA;
          tx_bit_d = sh_q[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_q == BW'(WIDTH - 1)) begin
            bit_d    = '0;
`ifdef DS_SERIAL_TX_PARITY_EN
            state_d  = PARITY;
            tx_bit_d = par_q;
`else
            state_d  = STOP;
            tx_bit_d = 1'b1;
`endif
          end else begin
            bit_d    = bit_q + BW'(1);
            sh_d     = sh_nxt;
            tx_bit_d = sh_nxt[0];
          end
        end
      end
`ifdef DS_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          state_d  = STOP;
          tx_bit_d = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          state_d  = IDLE;
          rdy_d    = 1'b1;
          tx_bit_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        tx_bit_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= 16'd0;
      bit_q    <= '0;
      sh_q     <= '0;
      tx_bit_q <= 1'b1;
      rdy_q    <= 1'b0;
`ifdef DS_SERIAL_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      tx_bit_q <= tx_bit_d;
      rdy_q    <= rdy_d;
`ifdef DS_SERIAL_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign din_ready = rdy_q;
  assign busy      = (state_q != IDLE);

  O_BUF_DS u_obuf (
    .I   (tx_bit_q),
    .O_P (tx_p),
    .O_N (tx_n)
  );
endmodule

// File: tb/tb_ds_serial_tx.sv
// Bench for ds_serial_tx: vector table, corner sequences, random frames.
// Frames are predicted from the start/data/parity/stop rule.
module tb_ds_serial_tx;
  localparam int W  = 8;
  localparam int BD = 4;
`ifdef DS_SERIAL_TX_PARITY_EN
  localparam int FLEN = W + 3;
`else
  localparam int FLEN = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, busy, tx_p, tx_n;

  int vectors = 0;
  int miscompares = 0;

  ds_serial_tx #(.WIDTH(W), .BAUD_DIV(BD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .busy      (busy),
    .tx_p      (tx_p),
    .tx_n      (tx_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] din;
    logic [63:0]  frame;
    bit           mid;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_frame(input logic [W-1:0] w);
    logic [63:0] f;
    int ones;
    f = '0;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < W; i++) begin
      f[1+i] = w[i];
      if (w[i]) ones++;
    end
`ifdef DS_SERIAL_TX_PARITY_EN
    f[W+1] = (ones % 2 == 1);
    f[W+2] = 1'b1;
`else
    f[W+1] = 1'b1;
`endif
    return f;
  endfunction

  // Called at a negedge; returns at the negedge of the first frame cycle.
  task automatic start_word(input logic [W-1:0] w, input bit hold);
    int n;
    n = 0;
    while (!din_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", din_ready, 1'b1);
    din = w;
    din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) din_valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [63:0] fr, input bit noise,
                              input bit mid_zero);
    for (int c = 0; c < FLEN * BD; c++) begin
      chk("tx_p", tx_p, fr[c/BD]);
      chk("tx_n", tx_n, ~fr[c/BD]);
      chk("busy", busy, 1'b1);
      chk("ready_low", din_ready, 1'b0);
      if (mid_zero && c == 2 * BD) din = '0;
      if (noise) begin
        din = W'($urandom);
        din_valid = (c != FLEN * BD - 1) && ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
    end
    chk("idle_ready", din_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_tx_p", tx_p, 1'b1);
    chk("idle_tx_n", tx_n, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] fr;
`ifdef DS_SERIAL_TX_PARITY_EN
    tbl[0] = '{8'hA5, 64'(11'b1_0_10100101_0), 1'b0};
    tbl[1] = '{8'h07, 64'(11'b1_1_00000111_0), 1'b0};
    tbl[2] = '{8'h00, 64'(11'b1_0_00000000_0), 1'b0};
    tbl[3] = '{8'hFF, 64'(11'b1_0_11111111_0), 1'b0};
    tbl[4] = '{8'h01, 64'(11'b1_1_00000001_0), 1'b0};
    tbl[5] = '{8'hF0, 64'(11'b1_0_11110000_0), 1'b1};
`else
    tbl[0] = '{8'hA5, 64'(10'b1_10100101_0), 1'b0};
    tbl[1] = '{8'h07, 64'(10'b1_00000111_0), 1'b0};
    tbl[2] = '{8'h00, 64'(10'b1_00000000_0), 1'b0};
    tbl[3] = '{8'hFF, 64'(10'b1_11111111_0), 1'b0};
    tbl[4] = '{8'h01, 64'(10'b1_00000001_0), 1'b0};
    tbl[5] = '{8'hF0, 64'(10'b1_11110000_0), 1'b1};
`endif

    // Reset state and idle after release
    #12;
    chk("rst_tx_p", tx_p, 1'b1);
    chk("rst_tx_n", tx_n, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", din_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_ready", din_ready, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", din_ready, 1'b1);
      chk("idle_tx_p", tx_p, 1'b1);
      chk("idle_tx_n", tx_n, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end

    // Vector table, including din changing to 0 mid-DATA
    foreach (tbl[i]) begin
      start_word(tbl[i].din, 1'b0);
      expect_frame(tbl[i].frame, 1'b0, tbl[i].mid);
    end

    // din_valid held: back-to-back frames one idle cycle apart
    start_word(8'h01, 1'b1);
    din = 8'hFF;
    expect_frame(model_frame(8'h01), 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    expect_frame(model_frame(8'hFF), 1'b0, 1'b0);

    // Asynchronous abort in cycle 13 of a 0x3C frame
    start_word(8'h3C, 1'b0);
    fr = model_frame(8'h3C);
    for (int c = 0; c < 12; c++) begin
      chk("abort_pre_tx_p", tx_p, fr[c/BD]);
      @(negedge clk);
    end
    chk("abort_pre_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_tx_p", tx_p, 1'b1);
    chk("abort_tx_n", tx_n, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", din_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_rel_ready", din_ready, 1'b0);
    @(negedge clk);
    chk("abort_rel_ready1", din_ready, 1'b1);
    chk("abort_rel_tx_p", tx_p, 1'b1);
    start_word(8'h55, 1'b0);
    expect_frame(model_frame(8'h55), 1'b0, 1'b0);

    // Random words with noise on din/din_valid while busy
    for (int k = 0; k < 30; k++) begin
      logic [W-1:0] w;
      w = W'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_word(w, 1'b0);
      expect_frame(model_frame(w), 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
